sipmroc_event_serializer: RTL

//   Next-generation SiPMROC event builder and serial readout. Collects per-channel pulse-measurement

---
 rtl/sipmroc_event_serializer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sipmroc_event_serializer.sv
// SiPMROC event builder: gathers masked channel measurements into events, queues closed
// frames in a small FIFO and streams them MSB first on a single serial line.

module sipmroc_ch_capture #(
  parameter int ADC_WIDTH = 10
) (
  input  logic                 clk_200m,
  input  logic                 rst,
  input  logic                 cap,
  input  logic                 clr,
  input  logic [ADC_WIDTH-1:0] din,
  output logic                 hit,
  output logic [ADC_WIDTH-1:0] dout
);
  // cap is only raised for an unhit channel, so the first value wins
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      hit  <= 1'b0;
      dout <= '0;
    end else if (clr) begin
      hit  <= 1'b0;
      dout <= '0;
    end else if (cap) begin
      hit  <= 1'b1;
      dout <= din;
    end
  end
endmodule

module sipmroc_event_serializer #(
  parameter int         ADC_WIDTH   = 10,
  parameter int         CH_NUM      = 17,
  parameter int         EVT_CNT_W   = 8,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter logic [7:0] TRAILER     = 8'h55
) (
  input  logic                          clk_200m,
  input  logic                          rst,
  input  logic [CH_NUM*ADC_WIDTH-1:0]   ch_data,
  input  logic [CH_NUM-1:0]             ch_data_val,
  input  logic [CH_NUM-1:0]             ch_mask,
  output logic                          meas_rst,
  output logic                          serial_data_en,
  output logic                          serial_data,
  output logic                          fifo_overflow,
  output logic                          busy
);
  localparam int FRAME_W = 16 + EVT_CNT_W + CH_NUM + CH_NUM*ADC_WIDTH;
  localparam int TCNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef struct packed {
    logic [7:0]                       header;
    logic [EVT_CNT_W-1:0]             cnt;
    logic [CH_NUM-1:0]                hit;
    logic [CH_NUM-1:0][ADC_WIDTH-1:0] data;
    logic [7:0]                       trailer;
  } frame_t;

  typedef enum logic [1:0] {C_IDLE, C_COLLECT, C_CLOSE} cst_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT}    sst_t;

  cst_t cstate, cnext;
  sst_t sstate, snext;

  logic [CH_NUM-1:0][ADC_WIDTH-1:0] ch_din, cap_data;
  logic [CH_NUM-1:0]                evt_mask, hit, sel_mask, new_hits, hit_next;
  logic [EVT_CNT_W-1:0]             evt_cnt;
  logic [TCNT_W-1:0]                tcnt;
  logic                             tmo, closing;

  frame_t               wr_frame, head;
  logic [FRAME_W-1:0]   head_bits, sreg;
  frame_t               mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 cool;

  assign ch_din = ch_data;

  // ---------------- per-channel capture ----------------
  assign new_hits = ch_data_val & sel_mask & ~hit;
  assign hit_next = hit | new_hits;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    sipmroc_ch_capture #(.ADC_WIDTH(ADC_WIDTH)) u_cap (
      .clk_200m (clk_200m),
      .rst      (rst),
      .cap      (new_hits[k]),
      .clr      (closing),
      .din      (ch_din[k]),
      .hit      (hit[k]),
      .dout     (cap_data[k])
    );
  end

  // ---------------- collector FSM ----------------
  assign tmo = (TIMEOUT_CYC != 0) && (tcnt == TMO_LAST);

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) cstate <= C_IDLE;
    else     cstate <= cnext;
  end

  // an opening strobe that already covers the whole mask closes without a COLLECT cycle
  always_comb begin
    cnext = cstate;
    case (cstate)
      C_IDLE:    if (|new_hits) cnext = (hit_next == ch_mask) ? C_CLOSE : C_COLLECT;
      C_COLLECT: if ((hit_next == evt_mask) || tmo) cnext = C_CLOSE;
      C_CLOSE:   cnext = C_IDLE;
      default:   cnext = C_IDLE;
    endcase
  end

  always_comb begin
    closing  = 1'b0;
    sel_mask = '0;
    case (cstate)
      C_IDLE:    sel_mask = ch_mask;
      C_COLLECT: sel_mask = evt_mask;
      C_CLOSE:   closing  = 1'b1;
      default:   sel_mask = '0;
    endcase
  end

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      evt_mask <= '0;
      tcnt     <= '0;
      evt_cnt  <= '0;
    end else begin
      if (cstate == C_IDLE) begin
        tcnt <= '0;
        if (|new_hits) evt_mask <= ch_mask;
      end
      if (cstate == C_COLLECT) tcnt <= tcnt + 1'b1;
      if (closing) evt_cnt <= evt_cnt + 1'b1;
    end
  end

  // ---------------- frame FIFO ----------------
  always_comb begin
    wr_frame.header  = HEADER;
    wr_frame.cnt     = evt_cnt;
    wr_frame.hit     = hit;
    wr_frame.data    = cap_data;
    wr_frame.trailer = TRAILER;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the frame
  assign push       = closing & (~fifo_full | pop);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_bits  = head;

  always_ff @(posedge clk_200m) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_frame;
  end

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- serializer FSM ----------------
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) sstate <= S_IDLE;
    else     sstate <= snext;
  end

  // cool holds S_IDLE for one extra cycle after a frame so frames stay >= 2 cycles apart
  always_comb begin
    snext = sstate;
    case (sstate)
      S_IDLE:  if (!fifo_empty && !cool) snext = S_LOAD;
      S_LOAD:  snext = S_SHIFT;
      S_SHIFT: if (bit_cnt == '0) snext = S_IDLE;
      default: snext = S_IDLE;
    endcase
  end

  // S_LOAD drives the frame MSB straight from the FIFO head while it is popped
  always_comb begin
    pop            = 1'b0;
    serial_data_en = 1'b0;
    serial_data    = 1'b0;
    case (sstate)
      S_LOAD: begin
        pop            = 1'b1;
        serial_data_en = 1'b1;
        serial_data    = head_bits[FRAME_W-1];
      end
      S_SHIFT: begin
        serial_data_en = 1'b1;
        serial_data    = sreg[FRAME_W-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      cool    <= 1'b0;
    end else begin
      cool <= (sstate == S_SHIFT) && (bit_cnt == '0);
      if (sstate == S_LOAD) begin
        sreg    <= {head_bits[FRAME_W-2:0], 1'b0};
        bit_cnt <= BIT_W'(FRAME_W - 2);
      end else if (sstate == S_SHIFT) begin
        sreg    <= {sreg[FRAME_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  // ---------------- status outputs ----------------
  assign meas_rst      = closing;
  assign fifo_overflow = closing & fifo_full & ~pop;
  assign busy          = (cstate != C_IDLE) | ~fifo_empty | (sstate != S_IDLE);

endmodule
